// File: rtl/usf_sample_window_if.sv
// rtl/usf_sample_window_if.sv - sample-in / frame-out bundle for the ultrasound sample window
//
// Ports (signals):
//   sample_valid  qualifies sample for one cycle (master -> slave)
//   sample        raw unsigned ADC code (master -> slave)
//   win           frame samples, win[0] oldest, win[WINDOW-1] newest (slave -> master)
//   frame_en      one-cycle pulse: win holds a complete frame (slave -> master)
//   busy          window frozen, frame being issued or held (slave -> master)
//   frame_cnt     frames issued, wrapping (slave -> master)
//   overrun_cnt   valid samples dropped, saturating (slave -> master)
interface usf_sample_window_if #(
    parameter int ADC_RES = 12,
    parameter int WINDOW  = 4
);
    logic               sample_valid;
    logic [ADC_RES-1:0] sample;
    logic [ADC_RES-1:0] win [WINDOW];
    logic               frame_en;
    logic               busy;
    logic [15:0]        frame_cnt;
    logic [15:0]        overrun_cnt;

    modport master (
        output sample_valid, sample,
        input  win, frame_en, busy, frame_cnt, overrun_cnt
    );

    modport slave (
        input  sample_valid, sample,
        output win, frame_en, busy, frame_cnt, overrun_cnt
    );
endinterface

// File: rtl/usf_sample_window.sv
// rtl/usf_sample_window.sv - collects decimated ADC samples into an overlapping, frozen frame window
//
// Ports:
//   clk    single clock, all state on posedge
//   reset  asynchronous active-low reset
//   bus    usf_sample_window_if.slave: sample_valid/sample in; win, frame_en,
//          busy, frame_cnt, overrun_cnt out
//
// FILL shifts accepted samples into the window. Once WINDOW samples are present
// the frame is issued for one cycle (ISSUE) and then frozen for HOLD_CYCLES
// (HOLD) while the downstream recovery logic reads it. Samples arriving while
// frozen are dropped and counted. Returning to FILL keeps the newest OVERLAP
// samples as the oldest of the next frame.
module usf_sample_window #(
    parameter int ADC_RES       = 12,
    parameter int J             = 2,
    parameter int EXTRA_SAMPLES = 1,
    parameter int WINDOW        = J + 1 + EXTRA_SAMPLES,
    parameter int OVERLAP       = 0,
    parameter int DECIM         = 1,
    parameter int HOLD_CYCLES   = 64
) (
    input  logic                clk,
    input  logic                reset,
    usf_sample_window_if.slave  bus
);
    localparam int FW = $clog2(WINDOW + 1);
    localparam int DW = (DECIM > 1) ? $clog2(DECIM) : 1;
    localparam int HW = $clog2(HOLD_CYCLES + 1);

    localparam logic [FW-1:0] FILL_LAST  = FW'(WINDOW - 1);
    localparam logic [FW-1:0] FILL_KEEP  = FW'(OVERLAP);
    localparam logic [DW-1:0] DECIM_LAST = DW'(DECIM - 1);
    localparam logic [HW-1:0] HOLD_LAST  = HW'(HOLD_CYCLES - 1);

    typedef enum logic [1:0] {
        FILL  = 2'd0,
        ISSUE = 2'd1,
        HOLD  = 2'd2
    } state_t;

    state_t             state;
    logic [ADC_RES-1:0] win_q [WINDOW];
    logic [FW-1:0]      fill_cnt;
    logic [DW-1:0]      decim_cnt;
    logic [HW-1:0]      hold_cnt;
    logic [15:0]        frame_cnt;
    logic [15:0]        overrun_cnt;
    logic               frame_en;
    logic               busy;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= FILL;
            fill_cnt    <= '0;
            decim_cnt   <= '0;
            hold_cnt    <= '0;
            frame_cnt   <= '0;
            overrun_cnt <= '0;
            frame_en    <= 1'b0;
            busy        <= 1'b0;
            for (int i = 0; i < WINDOW; i++) begin
                win_q[i] <= '0;
            end
        end else begin
            case (state)
                FILL: begin
                    if (bus.sample_valid) begin
                        decim_cnt <= (decim_cnt == DECIM_LAST) ? '0 : decim_cnt + 1'b1;
                        if (decim_cnt == '0) begin
                            for (int i = 0; i < WINDOW - 1; i++) begin
                                win_q[i] <= win_q[i+1];
                            end
                            win_q[WINDOW-1] <= bus.sample;
                            fill_cnt        <= fill_cnt + 1'b1;
                            // Completing sample: frame goes out on the very next cycle.
                            if (fill_cnt == FILL_LAST) begin
                                state    <= ISSUE;
                                frame_en <= 1'b1;
                                busy     <= 1'b1;
                            end
                        end
                    end
                end
                ISSUE: begin
                    state     <= HOLD;
                    frame_en  <= 1'b0;
                    hold_cnt  <= '0;
                    frame_cnt <= frame_cnt + 1'b1;
                end
                HOLD: begin
                    if (hold_cnt == HOLD_LAST) begin
                        // Window is left untouched so the newest OVERLAP samples carry over.
                        state     <= FILL;
                        busy      <= 1'b0;
                        hold_cnt  <= '0;
                        fill_cnt  <= FILL_KEEP;
                        decim_cnt <= '0;
                    end else begin
                        hold_cnt <= hold_cnt + 1'b1;
                    end
                end
                default: begin
                    state    <= FILL;
                    frame_en <= 1'b0;
                    busy     <= 1'b0;
                end
            endcase

            // Any valid sample while the window is frozen (including the
            // HOLD->FILL edge) is lost; the counter sticks at all-ones.
            if (bus.sample_valid && state != FILL && overrun_cnt != 16'hFFFF) begin
                overrun_cnt <= overrun_cnt + 1'b1;
            end
        end
    end

    assign bus.win         = win_q;
    assign bus.frame_en    = frame_en;
    assign bus.busy        = busy;
    assign bus.frame_cnt   = frame_cnt;
    assign bus.overrun_cnt = overrun_cnt;

endmodule

// File: tb/tb_usf_sample_window.sv
// tb/tb_usf_sample_window.sv - directed self-checking bench for usf_sample_window
module tb_usf_sample_window;
    logic clk   = 1'b0;
    logic reset = 1'b0;
    int   checks   = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    usf_sample_window_if #(.ADC_RES(12), .WINDOW(4)) if_a ();
    usf_sample_window_if #(.ADC_RES(12), .WINDOW(4)) if_b ();
    usf_sample_window_if #(.ADC_RES(12), .WINDOW(4)) if_c ();
    usf_sample_window_if #(.ADC_RES(12), .WINDOW(4)) if_d ();

    usf_sample_window #(.ADC_RES(12), .WINDOW(4), .OVERLAP(0), .DECIM(1), .HOLD_CYCLES(8))
        dut_a (.clk(clk), .reset(reset), .bus(if_a));
    usf_sample_window #(.ADC_RES(12), .WINDOW(4), .OVERLAP(2), .DECIM(1), .HOLD_CYCLES(8))
        dut_b (.clk(clk), .reset(reset), .bus(if_b));
    usf_sample_window #(.ADC_RES(12), .WINDOW(4), .OVERLAP(0), .DECIM(3), .HOLD_CYCLES(8))
        dut_c (.clk(clk), .reset(reset), .bus(if_c));
    usf_sample_window #(.ADC_RES(12), .WINDOW(4), .OVERLAP(0), .DECIM(1), .HOLD_CYCLES(70000))
        dut_d (.clk(clk), .reset(reset), .bus(if_d));

    function automatic logic [47:0] pack_a();
        return {if_a.win[0], if_a.win[1], if_a.win[2], if_a.win[3]};
    endfunction
    function automatic logic [47:0] pack_b();
        return {if_b.win[0], if_b.win[1], if_b.win[2], if_b.win[3]};
    endfunction
    function automatic logic [47:0] pack_c();
        return {if_c.win[0], if_c.win[1], if_c.win[2], if_c.win[3]};
    endfunction

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_all();
        if_a.sample_valid = 1'b0; if_a.sample = '0;
        if_b.sample_valid = 1'b0; if_b.sample = '0;
        if_c.sample_valid = 1'b0; if_c.sample = '0;
        if_d.sample_valid = 1'b0; if_d.sample = '0;
    endtask

    task automatic apply_reset();
        idle_all();
        reset = 1'b0;
        cyc();
        cyc();
        reset = 1'b1;
    endtask

    task automatic test_reset();
        idle_all();
        reset = 1'b0;
        #2;
        checks++; if (if_a.frame_en !== 1'b0) begin failures++; $display("FAIL reset_frame_en: got %b expected 0", if_a.frame_en); end
        checks++; if (if_a.busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b expected 0", if_a.busy); end
        checks++; if (if_a.frame_cnt !== 16'd0) begin failures++; $display("FAIL reset_frame_cnt: got %0d expected 0", if_a.frame_cnt); end
        checks++; if (if_a.overrun_cnt !== 16'd0) begin failures++; $display("FAIL reset_overrun_cnt: got %0d expected 0", if_a.overrun_cnt); end
        checks++; if (pack_a() !== 48'd0) begin failures++; $display("FAIL reset_win: got %h expected 0", pack_a()); end
        cyc();
        cyc();
        reset = 1'b1;
    endtask

    task automatic test_single_frame();
        logic early;
        int   busy_n;
        apply_reset();
        early = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            if_a.sample_valid = 1'b1;
            if_a.sample = 12'(k);
            cyc();
            if (k < 4) early = early | if_a.frame_en;
        end
        if_a.sample_valid = 1'b0;
        checks++; if (early !== 1'b0) begin failures++; $display("FAIL single_early_frame_en: got %b expected 0", early); end
        checks++; if (if_a.frame_en !== 1'b1) begin failures++; $display("FAIL single_frame_en: got %b expected 1", if_a.frame_en); end
        checks++; if (pack_a() !== {12'd1, 12'd2, 12'd3, 12'd4}) begin failures++; $display("FAIL single_win: got %h expected 001002003004", pack_a()); end
        busy_n = 1;
        for (int i = 0; i < 20; i++) begin
            cyc();
            if (i == 0) begin
                checks++; if (if_a.frame_en !== 1'b0) begin failures++; $display("FAIL single_frame_en_width: got %b expected 0", if_a.frame_en); end
                checks++; if (if_a.frame_cnt !== 16'd1) begin failures++; $display("FAIL single_frame_cnt: got %0d expected 1", if_a.frame_cnt); end
            end
            if (!if_a.busy) break;
            busy_n++;
        end
        checks++; if (busy_n != 9) begin failures++; $display("FAIL single_busy_cycles: got %0d expected 9", busy_n); end
    endtask

    task automatic test_continuous();
        int          fe_n, frozen_bad, consec;
        int          fe_t [3];
        logic [15:0] ov_at [3];
        logic [47:0] snap, win_f2;
        logic        prev_fe;
        apply_reset();
        fe_n = 0; frozen_bad = 0; consec = 0; prev_fe = 1'b0;
        snap = '0; win_f2 = '0;
        for (int i = 0; i < 3; i++) begin fe_t[i] = 0; ov_at[i] = '0; end
        for (int t = 1; t <= 40; t++) begin
            if_a.sample_valid = 1'b1;
            if_a.sample = 12'(t);
            cyc();
            if (if_a.frame_en) begin
                if (prev_fe) consec++;
                if (fe_n < 3) begin fe_t[fe_n] = t; ov_at[fe_n] = if_a.overrun_cnt; end
                if (fe_n == 1) win_f2 = pack_a();
                fe_n++;
                snap = pack_a();
            end else if (if_a.busy && pack_a() !== snap) begin
                frozen_bad++;
            end
            prev_fe = if_a.frame_en;
        end
        if_a.sample_valid = 1'b0;
        checks++; if (fe_n != 3) begin failures++; $display("FAIL cont_frame_count: got %0d expected 3", fe_n); end
        checks++; if (fe_t[0] != 4 || fe_t[1] != 17 || fe_t[2] != 30) begin failures++; $display("FAIL cont_frame_times: got %0d,%0d,%0d expected 4,17,30", fe_t[0], fe_t[1], fe_t[2]); end
        checks++; if (ov_at[0] !== 16'd0 || ov_at[1] !== 16'd9 || ov_at[2] !== 16'd18) begin failures++; $display("FAIL cont_overrun_per_frame: got %0d,%0d,%0d expected 0,9,18", ov_at[0], ov_at[1], ov_at[2]); end
        checks++; if (if_a.overrun_cnt !== 16'd27) begin failures++; $display("FAIL cont_overrun_total: got %0d expected 27", if_a.overrun_cnt); end
        checks++; if (win_f2 !== {12'd14, 12'd15, 12'd16, 12'd17}) begin failures++; $display("FAIL cont_win_frame2: got %h expected 00e00f010011", win_f2); end
        checks++; if (frozen_bad != 0) begin failures++; $display("FAIL cont_win_frozen: got %0d changes expected 0", frozen_bad); end
        checks++; if (consec != 0) begin failures++; $display("FAIL cont_frame_en_consecutive: got %0d expected 0", consec); end
        checks++; if (if_a.frame_cnt !== 16'd3) begin failures++; $display("FAIL cont_frame_cnt: got %0d expected 3", if_a.frame_cnt); end
    endtask

    task automatic test_overlap();
        int          fe_n;
        logic [47:0] fr [2];
        apply_reset();
        fe_n = 0; fr[0] = '0; fr[1] = '0;
        for (int k = 1; k <= 6; k++) begin
            for (int j = 0; j < 13; j++) begin
                if_b.sample_valid = (j == 0);
                if_b.sample = 12'(k);
                cyc();
                if (if_b.frame_en) begin
                    if (fe_n < 2) fr[fe_n] = pack_b();
                    fe_n++;
                end
            end
        end
        if_b.sample_valid = 1'b0;
        checks++; if (fe_n != 2) begin failures++; $display("FAIL overlap_frame_count: got %0d expected 2", fe_n); end
        checks++; if (fr[0] !== {12'd1, 12'd2, 12'd3, 12'd4}) begin failures++; $display("FAIL overlap_frame1: got %h expected 001002003004", fr[0]); end
        checks++; if (fr[1] !== {12'd3, 12'd4, 12'd5, 12'd6}) begin failures++; $display("FAIL overlap_frame2: got %h expected 003004005006", fr[1]); end
        checks++; if (if_b.overrun_cnt !== 16'd0) begin failures++; $display("FAIL overlap_overrun: got %0d expected 0", if_b.overrun_cnt); end
    endtask

    task automatic test_decim();
        int          fe_n;
        logic [47:0] fr;
        apply_reset();
        fe_n = 0; fr = '0;
        for (int i = 0; i < 24; i++) begin
            if_c.sample_valid = (i < 12);
            if_c.sample = 12'(i);
            cyc();
            if (if_c.frame_en) begin
                if (fe_n == 0) fr = pack_c();
                fe_n++;
            end
        end
        if_c.sample_valid = 1'b0;
        checks++; if (fe_n != 1) begin failures++; $display("FAIL decim_frame_count: got %0d expected 1", fe_n); end
        checks++; if (fr !== {12'd0, 12'd3, 12'd6, 12'd9}) begin failures++; $display("FAIL decim_win: got %h expected 000003006009", fr); end
        checks++; if (if_c.overrun_cnt !== 16'd2) begin failures++; $display("FAIL decim_overrun: got %0d expected 2", if_c.overrun_cnt); end
        checks++; if (if_c.frame_cnt !== 16'd1) begin failures++; $display("FAIL decim_frame_cnt: got %0d expected 1", if_c.frame_cnt); end
    endtask

    task automatic test_abort();
        int fe_n;
        apply_reset();
        for (int k = 1; k <= 4; k++) begin
            if_a.sample_valid = 1'b1;
            if_a.sample = 12'(k);
            cyc();
        end
        if_a.sample_valid = 1'b0;
        cyc();
        cyc();
        cyc();
        checks++; if (if_a.busy !== 1'b1 || if_a.frame_cnt !== 16'd1) begin failures++; $display("FAIL abort_in_hold: got busy=%b frame_cnt=%0d expected busy=1 frame_cnt=1", if_a.busy, if_a.frame_cnt); end
        #2;
        reset = 1'b0;
        #1;
        checks++; if (if_a.busy !== 1'b0 || if_a.frame_en !== 1'b0) begin failures++; $display("FAIL abort_async_flags: got busy=%b frame_en=%b expected 0,0", if_a.busy, if_a.frame_en); end
        checks++; if (if_a.frame_cnt !== 16'd0 || if_a.overrun_cnt !== 16'd0) begin failures++; $display("FAIL abort_async_counts: got %0d,%0d expected 0,0", if_a.frame_cnt, if_a.overrun_cnt); end
        checks++; if (pack_a() !== 48'd0) begin failures++; $display("FAIL abort_async_win: got %h expected 0", pack_a()); end
        @(posedge clk);
        #1;
        reset = 1'b1;
        fe_n = 0;
        for (int i = 0; i < 20; i++) begin
            cyc();
            if (if_a.frame_en) fe_n++;
        end
        for (int k = 21; k <= 24; k++) begin
            if_a.sample_valid = 1'b1;
            if_a.sample = 12'(k);
            cyc();
            if (k < 24 && if_a.frame_en) fe_n++;
        end
        if_a.sample_valid = 1'b0;
        checks++; if (fe_n != 0) begin failures++; $display("FAIL abort_stray_frame_en: got %0d expected 0", fe_n); end
        checks++; if (if_a.frame_en !== 1'b1) begin failures++; $display("FAIL abort_next_frame_en: got %b expected 1", if_a.frame_en); end
        checks++; if (pack_a() !== {12'd21, 12'd22, 12'd23, 12'd24}) begin failures++; $display("FAIL abort_next_win: got %h expected 015016017018", pack_a()); end
    endtask

    task automatic test_saturate();
        apply_reset();
        for (int i = 1; i <= 70004; i++) begin
            if_d.sample_valid = 1'b1;
            if_d.sample = 12'(i);
            cyc();
            if (i == 65538) begin
                checks++; if (if_d.overrun_cnt !== 16'hFFFE) begin failures++; $display("FAIL sat_before_limit: got %h expected fffe", if_d.overrun_cnt); end
            end
        end
        if_d.sample_valid = 1'b0;
        checks++; if (if_d.overrun_cnt !== 16'hFFFF) begin failures++; $display("FAIL sat_overrun: got %h expected ffff", if_d.overrun_cnt); end
        checks++; if (if_d.frame_cnt !== 16'd1 || if_d.busy !== 1'b1) begin failures++; $display("FAIL sat_state: got frame_cnt=%0d busy=%b expected 1,1", if_d.frame_cnt, if_d.busy); end
    endtask

    initial begin
        idle_all();
        test_reset();
        test_single_frame();
        test_continuous();
        test_overlap();
        test_decim();
        test_abort();
        test_saturate();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/usf_sample_window.md
USF_SAMPLE_WINDOW -- requirements
Module: usf_sample_window

Interface
REQ-001 The block SHALL have parameter ADC_RES, default 12: ADC sample width in bits.
REQ-002 The block SHALL have parameter WINDOW, default J+1+EXTRA_SAMPLES: samples per frame, at least 2.
REQ-003 The block SHALL have parameter OVERLAP, default 0: samples kept from the previous frame, 0..WINDOW-1.
REQ-004 The block SHALL have parameter DECIM, default 1: accept 1 of every DECIM valid samples, at least 1.
REQ-005 The block SHALL have parameter HOLD_CYCLES, default 64: cycles the window stays frozen after frame_en, covering the downstream recovery pipeline, at least 1.
REQ-006 clk  input  1  single clock; all state updates on posedge clk.
REQ-007 reset  input  1  asynchronous, active-low reset.
REQ-008 sample_valid  input  1  qualifies sample for one cycle.
REQ-009 sample  input  ADC_RES  raw unsigned ADC code.
REQ-010 win  output  [ADC_RES-1:0] x WINDOW unpacked array  frame samples; win[0] oldest, win[WINDOW-1] newest.
REQ-011 frame_en  output  1  one-cycle pulse meaning win holds a complete frame; drives the recovery block's en.
REQ-012 busy  output  1  high in states ISSUE and HOLD.
REQ-013 frame_cnt  output  16  frames issued, wraps at 0xFFFF to 0.
REQ-014 overrun_cnt  output  16  valid samples dropped, saturates at 0xFFFF.

Function
REQ-015 The block SHALL implement states FILL, ISSUE and HOLD, all registered.
REQ-016 In FILL, a valid sample SHALL be accepted when decim_cnt==0.
REQ-017 On every valid sample in FILL, decim_cnt SHALL advance modulo DECIM.
REQ-018 An accepted sample SHALL shift win down: win[i] takes win[i+1], win[WINDOW-1] takes sample, and fill_cnt increments.
REQ-019 A valid sample in FILL with decim_cnt!=0 SHALL be discarded without counting as an overrun.
REQ-020 When an accepted sample makes fill_cnt equal WINDOW, the state SHALL go FILL to ISSUE on that edge, so frame_en rises 1 cycle after the completing sample.
REQ-021 ISSUE SHALL last exactly 1 cycle with frame_en=1, then move to HOLD.
REQ-022 frame_cnt SHALL increment once on the edge leaving ISSUE.
REQ-023 HOLD SHALL last exactly HOLD_CYCLES cycles, counted by hold_cnt, then return to FILL.
REQ-024 On return to FILL, fill_cnt SHALL be set to OVERLAP and decim_cnt to 0.
REQ-025 On return to FILL, win SHALL be unchanged, so the newest OVERLAP samples are reused as the oldest of the next frame.
REQ-026 win SHALL be bit-stable from the ISSUE edge through the last HOLD cycle.
REQ-027 A sample_valid in ISSUE or HOLD SHALL be dropped: win unchanged and overrun_cnt incremented, saturating.
REQ-028 A sample_valid on the HOLD to FILL transition edge SHALL be dropped; acceptance resumes the following cycle.
REQ-029 frame_en SHALL never assert on two consecutive cycles.
REQ-030 The minimum frame period SHALL be 1+HOLD_CYCLES+(WINDOW-OVERLAP)*DECIM cycles.
REQ-031 With OVERLAP=0, the first frame SHALL need WINDOW accepted samples; later frames need WINDOW-OVERLAP.
REQ-032 Counters SHALL be sized to hold values up to WINDOW, DECIM-1 and HOLD_CYCLES without overflow.
REQ-033 The block SHALL do no arithmetic on sample data; offset and range limiting belong downstream.

Reset
REQ-034 On reset low, the block SHALL go to FILL at once, asynchronously, with all win entries, fill_cnt, decim_cnt, hold_cnt, frame_cnt and overrun_cnt at 0.
REQ-035 On reset low, frame_en and busy SHALL read 0.
REQ-036 Reset asserted during ISSUE or HOLD SHALL abort the frame: frame_cnt not incremented and no later frame_en for partial data.
REQ-037 Deassertion SHALL be synchronised externally; the first edge after release SHALL be able to accept a sample.

Verification (WINDOW=4, OVERLAP=0, DECIM=1, HOLD_CYCLES=8 unless stated)
REQ-038 Valid samples 1,2,3,4 on consecutive cycles -> frame_en for exactly 1 cycle after sample 4, win={1,2,3,4}, frame_cnt=1, busy high for 9 cycles.
REQ-039 Valid held high continuously for 40 cycles -> frame_en period 13 cycles, overrun_cnt +9 per frame, win frozen through each HOLD.
REQ-040 OVERLAP=2, samples 1..6 with gaps longer than HOLD -> frames {1,2,3,4} then {3,4,5,6}.
REQ-041 DECIM=3, valid every cycle with values 0..11 -> first frame win={0,3,6,9}.
REQ-042 Reset pulse in HOLD cycle 3 -> outputs zero at once, no further frame_en, next frame needs 4 new samples.
REQ-043 Force 70000 dropped samples -> overrun_cnt holds at 0xFFFF.
